// File: rtl/router_pkt_tx_if.sv
// Signal bundle between the packet transmitter, its host and the router input port.
interface router_pkt_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       start;
    logic [1:0] dest_addr;
    logic       busy;
    logic       err;
    logic [7:0] data_out;
    logic       packet_valid;
    logic [5:0] buf_count;
    logic       tx_busy;
    logic       done;
    logic       tx_err;
    logic       timeout;
    logic       rejected;

    // Host / stimulus side: drives the controls and the router feedback.
    modport master (
        output wr_en, wr_data, start, dest_addr, busy, err,
        input  data_out, packet_valid, buf_count, tx_busy, done, tx_err, timeout, rejected
    );

    // Transmitter side.
    modport slave (
        input  wr_en, wr_data, start, dest_addr, busy, err,
        output data_out, packet_valid, buf_count, tx_busy, done, tx_err, timeout, rejected
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers up to 63 payload bytes, then sends
// header {len,addr}, payload and an even-parity byte to the router,
// honouring busy back-pressure and collecting the router's error verdict.
module router_pkt_tx #(
    parameter int MAX_LEN     = 63,
    parameter int CHK_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            resetn,
    router_pkt_tx_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_CHECK
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] buf_mem [MAX_LEN];
    logic [5:0] buf_count_q, buf_count_d;
    logic [5:0] len_q, len_d;
    logic [1:0] addr_q, addr_d;
    logic [5:0] idx_q, idx_d;
    logic [7:0] acc_q, acc_d;
    logic [3:0] chk_q, chk_d;
    logic       tx_err_q, tx_err_d;
    logic       timeout_q, timeout_d;
    logic       done_q, done_d;
    logic       rejected_q, rejected_d;

    logic       wr_fire;
    logic [5:0] count_after_wr;
    logic [7:0] rd_byte;
    logic       accept;

    // Writes only land while idle and the buffer still has room.
    assign wr_fire        = (state_q == S_IDLE) && bus.wr_en && (buf_count_q != 6'(MAX_LEN));
    assign count_after_wr = buf_count_q + 6'(wr_fire);
    assign rd_byte        = buf_mem[idx_q];
    assign accept         = ~bus.busy;

    // Payload buffer write port (contents need no reset; buf_count defines validity).
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            buf_mem[buf_count_q] <= bus.wr_data;
        end
    end

    // Byte presented to the router; held while busy because the state does not move.
    always_comb begin
        bus.data_out     = 8'h00;
        bus.packet_valid = 1'b0;
        case (state_q)
            S_HEADER: begin
                bus.data_out     = {len_q, addr_q};
                bus.packet_valid = 1'b1;
            end
            S_PAYLOAD: begin
                bus.data_out     = rd_byte;
                bus.packet_valid = 1'b1;
            end
            S_PARITY: begin
                bus.data_out     = acc_q;
            end
            default: ;
        endcase
    end

    assign bus.buf_count = buf_count_q;
    assign bus.tx_busy   = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.tx_err    = tx_err_q;
    assign bus.timeout   = timeout_q;
    assign bus.rejected  = rejected_q;

    // Next-state logic: buffering, launch, byte sequencing and CHECK handling.
    always_comb begin
        state_d     = state_q;
        buf_count_d = buf_count_q;
        len_d       = len_q;
        addr_d      = addr_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        chk_d       = chk_q;
        tx_err_d    = tx_err_q;
        timeout_d   = timeout_q;
        done_d      = 1'b0;
        rejected_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                buf_count_d = count_after_wr;
                if (bus.start) begin
                    if ((count_after_wr == 6'd0) || (bus.dest_addr == 2'b11)) begin
                        rejected_d = 1'b1;
                    end else begin
                        len_d     = count_after_wr;
                        addr_d    = bus.dest_addr;
                        tx_err_d  = 1'b0;
                        timeout_d = 1'b0;
                        state_d   = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                if (accept) begin
                    acc_d   = {len_q, addr_q};
                    idx_d   = 6'd0;
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    acc_d = acc_q ^ rd_byte;
                    idx_d = idx_q + 6'd1;
                    if (idx_q == len_q - 6'd1) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (accept) begin
                    chk_d   = 4'd0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                tx_err_d = tx_err_q | bus.err;
                if (!bus.busy) begin
                    done_d      = 1'b1;
                    buf_count_d = 6'd0;
                    state_d     = S_IDLE;
                end else if (chk_q == 4'(CHK_TIMEOUT - 1)) begin
                    timeout_d   = 1'b1;
                    done_d      = 1'b1;
                    buf_count_d = 6'd0;
                    state_d     = S_IDLE;
                end else begin
                    chk_d = chk_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            buf_count_q <= 6'd0;
            len_q       <= 6'd0;
            addr_q      <= 2'd0;
            idx_q       <= 6'd0;
            acc_q       <= 8'h00;
            chk_q       <= 4'd0;
            tx_err_q    <= 1'b0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
            rejected_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_count_q <= buf_count_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            chk_q       <= chk_d;
            tx_err_q    <= tx_err_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
            rejected_q  <= rejected_d;
        end
    end

endmodule
